// File: rtl/radio_pkg.sv
// Shared definitions for the radio transmit sequencer: SPI opcodes,
// the 4-bit state encoding and frame framing constants.
package radio_pkg;

    localparam logic [7:0] CMD_SFLUSHTX = 8'h09;
    localparam logic [7:0] CMD_TXFIFO   = 8'h3E;
    localparam logic [7:0] CMD_STXON    = 8'h04;

    // CRC bytes appended by the radio, counted in the length byte.
    localparam int unsigned FCS_BYTES = 2;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FLUSH       = 4'd1,
        ST_FIFO_ADDR   = 4'd2,
        ST_LEN         = 4'd3,
        ST_DST         = 4'd4,
        ST_SRC         = 4'd5,
        ST_PAYLOAD     = 4'd6,
        ST_CCA_CHECK   = 4'd7,
        ST_BACKOFF     = 4'd8,
        ST_STROBE      = 4'd9,
        ST_WAIT_SFD_HI = 4'd10,
        ST_WAIT_SFD_LO = 4'd11,
        ST_DONE        = 4'd12,
        ST_FAIL        = 4'd13
    } tx_state_t;

endpackage

// File: rtl/radio_tx_sequencer_if.sv
// Byte-serial command bus between the sequencer and the SPI command master.
interface radio_tx_sequencer_if;
    logic [7:0] Command;
    logic       CmdValid;
    logic       CmdReady;

    modport master (output Command, output CmdValid, input CmdReady);
    modport slave  (input Command, input CmdValid, output CmdReady);
endinterface

// File: rtl/radio_tx_sequencer_timer.sv
// Loadable down-counter shared by the backoff and SFD wait phases.
// Holds at zero once expired; a load takes priority over counting.
module tx_wait_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Load on strobe, otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/radio_tx_sequencer.sv
// Radio transmit sequencer: flushes and loads the TX FIFO with an addressed
// frame, strobes STXON on clear channel with binary-exponential backoff,
// and follows SFD to report frame completion or failure.
module radio_tx_sequencer
    import radio_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES  = 4,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned BACKOFF_CYCLES = 2048,
    parameter int unsigned SFD_TIMEOUT    = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*PAYLOAD_BYTES-1:0] i_DIn,
    input  logic [7:0]                 i_SrcAddr,
    input  logic [7:0]                 i_DstAddr,
    input  logic                       i_InRequest,
    output logic                       o_InValid,
    input  logic                       i_CCA,
    input  logic                       i_SFD,
    radio_tx_sequencer_if.master       cmd_bus,
    output logic                       o_TransmitDone,
    output logic                       o_TransmitFail,
    output logic [3:0]                 o_CurState
);

    localparam int unsigned BO_MAX  = BACKOFF_CYCLES << MAX_RETRIES;
    localparam int unsigned TMR_MAX = (BO_MAX > SFD_TIMEOUT) ? BO_MAX : SFD_TIMEOUT;
    localparam int unsigned TW      = $clog2(TMR_MAX) + 1;
    localparam int unsigned IW      = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [2:0]  MAX_R   = 3'(MAX_RETRIES);
    localparam logic [7:0]  LEN_VAL = 8'(PAYLOAD_BYTES + 2 + FCS_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);

    tx_state_t                  r_state;
    logic [8*PAYLOAD_BYTES-1:0] r_payload;
    logic [7:0]                 r_src;
    logic [7:0]                 r_dst;
    logic [2:0]                 r_retries;
    logic [IW-1:0]              r_idx;
    logic [7:0]                 r_cmd;
    logic                       r_cmd_valid;
    logic                       r_in_valid;
    logic                       r_done;
    logic                       r_fail;

    logic                       w_tmr_load;
    logic [TW-1:0]              w_tmr_value;
    logic                       w_tmr_expired;
    logic [TW-1:0]              w_backoff_len;
    logic [TW-1:0]              w_sfd_len;
    logic [7:0]                 w_top_byte;
    logic [7:0]                 w_next_byte;
    logic                       w_busy_retry;

    // Timer holds N-1 so that the waiting state spans exactly N cycles,
    // leaving when the counter reads zero.
    assign w_backoff_len = (TW'(BACKOFF_CYCLES) << (r_retries + 3'd1)) - TW'(1);
    assign w_sfd_len     = TW'(SFD_TIMEOUT - 1);
    assign w_busy_retry  = !i_CCA && (r_retries < MAX_R);
    assign w_top_byte    = r_payload[8*PAYLOAD_BYTES-1 -: 8];

    if (PAYLOAD_BYTES > 1) begin : g_next_byte
        assign w_next_byte = r_payload[8*PAYLOAD_BYTES-9 -: 8];
    end else begin : g_single_byte
        assign w_next_byte = '0;
    end

    // Timer loads: backoff on busy channel, SFD timeout on entry to each wait phase.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = w_sfd_len;
        case (r_state)
            ST_CCA_CHECK: begin
                w_tmr_load  = w_busy_retry;
                w_tmr_value = w_backoff_len;
            end
            ST_STROBE:      w_tmr_load = cmd_bus.CmdReady;
            ST_WAIT_SFD_HI: w_tmr_load = i_SFD;
            default:        w_tmr_load = 1'b0;
        endcase
    end

    tx_wait_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_tmr_expired)
    );

    // Sequencer FSM; Command/CmdValid are set for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_payload   <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_retries   <= '0;
            r_idx       <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_in_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_in_valid <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_InRequest) begin
                        r_payload   <= i_DIn;
                        r_src       <= i_SrcAddr;
                        r_dst       <= i_DstAddr;
                        r_retries   <= '0;
                        r_in_valid  <= 1'b1;
                        r_cmd       <= CMD_SFLUSHTX;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (cmd_bus.CmdReady) begin
                        r_cmd   <= CMD_TXFIFO;
                        r_state <= ST_FIFO_ADDR;
                    end
                end
                ST_FIFO_ADDR: begin
                    if (cmd_bus.CmdReady) begin
                        r_cmd   <= LEN_VAL;
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (cmd_bus.CmdReady) begin
                        r_cmd   <= r_dst;
                        r_state <= ST_DST;
                    end
                end
                ST_DST: begin
                    if (cmd_bus.CmdReady) begin
                        r_cmd   <= r_src;
                        r_state <= ST_SRC;
                    end
                end
                ST_SRC: begin
                    if (cmd_bus.CmdReady) begin
                        r_cmd   <= w_top_byte;
                        r_idx   <= '0;
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (cmd_bus.CmdReady) begin
                        r_payload <= r_payload << 8;
                        if (r_idx == LAST_IDX) begin
                            r_cmd       <= '0;
                            r_cmd_valid <= 1'b0;
                            r_state     <= ST_CCA_CHECK;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                            r_cmd <= w_next_byte;
                        end
                    end
                end
                ST_CCA_CHECK: begin
                    if (i_CCA) begin
                        r_cmd       <= CMD_STXON;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ST_STROBE;
                    end else if (w_busy_retry) begin
                        r_retries <= r_retries + 3'd1;
                        r_state   <= ST_BACKOFF;
                    end else begin
                        r_fail  <= 1'b1;
                        r_state <= ST_FAIL;
                    end
                end
                ST_BACKOFF: begin
                    if (w_tmr_expired) begin
                        r_state <= ST_CCA_CHECK;
                    end
                end
                ST_STROBE: begin
                    if (cmd_bus.CmdReady) begin
                        r_cmd       <= '0;
                        r_cmd_valid <= 1'b0;
                        r_state     <= ST_WAIT_SFD_HI;
                    end
                end
                ST_WAIT_SFD_HI: begin
                    if (i_SFD) begin
                        r_state <= ST_WAIT_SFD_LO;
                    end else if (w_tmr_expired) begin
                        r_fail  <= 1'b1;
                        r_state <= ST_FAIL;
                    end
                end
                ST_WAIT_SFD_LO: begin
                    if (!i_SFD) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_tmr_expired) begin
                        r_fail  <= 1'b1;
                        r_state <= ST_FAIL;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                ST_FAIL:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_bus.Command  = r_cmd;
    assign cmd_bus.CmdValid = r_cmd_valid;
    assign o_InValid        = r_in_valid;
    assign o_TransmitDone   = r_done;
    assign o_TransmitFail   = r_fail;
    assign o_CurState       = r_state;

endmodule

// File: tb/tb_radio_tx_sequencer.sv
// Directed bench for radio_tx_sequencer: nominal frame, throttled ready,
// CCA backoff, retry exhaustion, SFD timeout and mid-frame reset.
module tb_radio_tx_sequencer;
    import radio_pkg::*;

    localparam int unsigned PB    = 4;
    localparam int unsigned SFD_T = 1000;

    logic            clk = 1'b0;
    logic            rst;
    logic [8*PB-1:0] i_DIn;
    logic [7:0]      i_SrcAddr;
    logic [7:0]      i_DstAddr;
    logic            i_InRequest;
    logic            o_InValid;
    logic            i_CCA;
    logic            i_SFD;
    logic            o_TransmitDone;
    logic            o_TransmitFail;
    logic [3:0]      o_CurState;

    radio_tx_sequencer_if bus ();

    radio_tx_sequencer #(
        .PAYLOAD_BYTES  (PB),
        .MAX_RETRIES    (3),
        .BACKOFF_CYCLES (2048),
        .SFD_TIMEOUT    (SFD_T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_DIn          (i_DIn),
        .i_SrcAddr      (i_SrcAddr),
        .i_DstAddr      (i_DstAddr),
        .i_InRequest    (i_InRequest),
        .o_InValid      (o_InValid),
        .i_CCA          (i_CCA),
        .i_SFD          (i_SFD),
        .cmd_bus        (bus),
        .o_TransmitDone (o_TransmitDone),
        .o_TransmitFail (o_TransmitFail),
        .o_CurState     (o_CurState)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q_cmd[$];
    logic [7:0] q_exp[$];
    int         q_bo[$];
    int         done_cnt, fail_cnt, inval_cnt;
    int         stx_cyc, fail_cyc, first_acc, last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input logic [31:0] din, input logic [7:0] src, input logic [7:0] dst,
                             input bit with_stx);
        q_exp.delete();
        q_exp.push_back(8'h09);
        q_exp.push_back(8'h3E);
        q_exp.push_back(8'h08);
        q_exp.push_back(dst);
        q_exp.push_back(src);
        q_exp.push_back(din[31:24]);
        q_exp.push_back(din[23:16]);
        q_exp.push_back(din[15:8]);
        q_exp.push_back(din[7:0]);
        if (with_stx) q_exp.push_back(8'h04);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, q_cmd.size(), q_exp.size());
        for (int i = 0; i < q_exp.size(); i++) begin
            if (i < q_cmd.size()) chk($sformatf("%s_b%0d", tag, i), q_cmd[i], q_exp[i]);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic start_req(input logic [31:0] din, input logic [7:0] src, input logic [7:0] dst);
        i_DIn       = din;
        i_SrcAddr   = src;
        i_DstAddr   = dst;
        i_InRequest = 1'b1;
        @(negedge clk);
        chk("req_invalid", o_InValid, 1);
        chk("req_state", o_CurState, 4'(ST_FLUSH));
        chk("req_valid", bus.CmdValid, 1);
        chk("req_cmd", bus.Command, 8'h09);
        i_InRequest = 1'b0;
        i_DIn       = 32'hFFFF_FFFF;
        i_SrcAddr   = 8'h00;
        i_DstAddr   = 8'h00;
    endtask

    // Drives ready/CCA/SFD and records the accepted byte stream until the frame ends.
    task automatic run_frame(input int rdy_mode, input int busy_checks, input bit sfd_pulse,
                             input int max_cyc);
        int         cyc = 0;
        int         bo_run = 0;
        int         checks = 0;
        int         sfd_phase = 0;
        bit         prev_hold = 1'b0;
        bit         finished = 1'b0;
        logic [7:0] prev_cmd = '0;
        q_cmd.delete();
        q_bo.delete();
        done_cnt = 0; fail_cnt = 0; inval_cnt = 0;
        stx_cyc = -1; fail_cyc = -1; first_acc = -1; last_acc = -1;
        while (cyc < max_cyc && !finished) begin
            if (prev_hold) begin
                chk("hold_cmd", bus.Command, prev_cmd);
                chk("hold_valid", bus.CmdValid, 1);
            end
            if (o_TransmitDone) done_cnt++;
            if (o_TransmitFail) begin fail_cnt++; fail_cyc = cyc; end
            if (cyc > 0 && o_InValid) inval_cnt++;
            if (o_CurState == 4'(ST_BACKOFF)) bo_run++;
            else if (bo_run != 0) begin q_bo.push_back(bo_run); bo_run = 0; end
            if (o_CurState == 4'(ST_CCA_CHECK)) begin
                i_CCA = (checks >= busy_checks);
                checks++;
            end
            if (sfd_phase == 1) begin i_SFD = 1'b1; sfd_phase = 2; end
            else if (sfd_phase == 2) begin i_SFD = 1'b0; sfd_phase = 3; end
            bus.CmdReady = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 2);
            if (bus.CmdValid && bus.CmdReady) begin
                q_cmd.push_back(bus.Command);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (o_CurState == 4'(ST_STROBE)) begin
                    stx_cyc = cyc;
                    if (sfd_pulse) sfd_phase = 1;
                end
            end
            prev_hold = bus.CmdValid && !bus.CmdReady;
            prev_cmd  = bus.Command;
            if ((done_cnt + fail_cnt) > 0 && o_CurState == 4'(ST_IDLE)) finished = 1'b1;
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("frame_finished", finished, 1);
        chk("inval_single", inval_cnt, 0);
    endtask

    initial begin
        rst          = 1'b1;
        i_DIn        = '0;
        i_SrcAddr    = '0;
        i_DstAddr    = '0;
        i_InRequest  = 1'b0;
        i_CCA        = 1'b1;
        i_SFD        = 1'b0;
        bus.CmdReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", o_CurState, 0);
        chk("rst_cmd", bus.Command, 8'h00);
        chk("rst_valid", bus.CmdValid, 0);
        chk("rst_invalid", o_InValid, 0);
        chk("rst_done", o_TransmitDone, 0);
        chk("rst_fail", o_TransmitFail, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_state", o_CurState, 0);

        // Nominal frame, ready tied high
        start_req(32'h12345678, 8'hAB, 8'hCD);
        run_frame(0, 0, 1'b1, 200);
        build_exp(32'h12345678, 8'hAB, 8'hCD, 1'b1);
        cmp_stream("nominal");
        chk("nominal_done", done_cnt, 1);
        chk("nominal_fail", fail_cnt, 0);
        chk("nominal_span", last_acc - first_acc, PB + 6);
        chk("nominal_nobo", q_bo.size(), 0);

        // Ready accepted one cycle in three
        start_req(32'h12345678, 8'hAB, 8'hCD);
        run_frame(1, 0, 1'b1, 400);
        cmp_stream("throttle");
        chk("throttle_done", done_cnt, 1);
        chk("throttle_fail", fail_cnt, 0);

        // Channel busy for two checks, then clear
        start_req(32'hA5C30F81, 8'h11, 8'h22);
        run_frame(0, 2, 1'b1, 20000);
        build_exp(32'hA5C30F81, 8'h11, 8'h22, 1'b1);
        cmp_stream("busy2");
        chk("busy2_nbo", q_bo.size(), 2);
        if (q_bo.size() > 0) chk("busy2_bo0", q_bo[0], 4096);
        if (q_bo.size() > 1) chk("busy2_bo1", q_bo[1], 8192);
        chk("busy2_done", done_cnt, 1);
        chk("busy2_fail", fail_cnt, 0);

        // Channel never clear: retries exhausted
        start_req(32'h0F1E2D3C, 8'h44, 8'h55);
        run_frame(0, 99, 1'b0, 40000);
        build_exp(32'h0F1E2D3C, 8'h44, 8'h55, 1'b0);
        cmp_stream("exhaust");
        chk("exhaust_nbo", q_bo.size(), 3);
        if (q_bo.size() > 0) chk("exhaust_bo0", q_bo[0], 4096);
        if (q_bo.size() > 1) chk("exhaust_bo1", q_bo[1], 8192);
        if (q_bo.size() > 2) chk("exhaust_bo2", q_bo[2], 16384);
        chk("exhaust_nostx", stx_cyc, -1);
        chk("exhaust_fail", fail_cnt, 1);
        chk("exhaust_done", done_cnt, 0);

        // SFD never rises; the acceptance edge sits one sample after stx_cyc
        start_req(32'h13579BDF, 8'h66, 8'h77);
        run_frame(0, 0, 1'b0, 3000);
        chk("sfdto_fail", fail_cnt, 1);
        chk("sfdto_done", done_cnt, 0);
        chk("sfdto_delay", fail_cyc - stx_cyc, SFD_T + 1);

        // Reset mid-payload, then a fresh frame
        start_req(32'hCAFEF00D, 8'h01, 8'h02);
        bus.CmdReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (o_CurState == 4'(ST_PAYLOAD)) break;
            @(negedge clk);
        end
        chk("rstmid_reached", o_CurState, 4'(ST_PAYLOAD));
        chk("rstmid_prevalid", bus.CmdValid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_valid", bus.CmdValid, 0);
        chk("rstmid_cmd", bus.Command, 8'h00);
        chk("rstmid_state", o_CurState, 0);
        chk("rstmid_fail", o_TransmitFail, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_idle", o_CurState, 0);
        chk("rstmid_done", o_TransmitDone, 0);
        start_req(32'hDEADBEEF, 8'h5A, 8'h3C);
        run_frame(0, 0, 1'b1, 200);
        build_exp(32'hDEADBEEF, 8'h5A, 8'h3C, 1'b1);
        cmp_stream("restart");
        chk("restart_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/radio_tx_sequencer.md
# radio_tx_sequencer

Parametrised successor to the radio transmit FSM: it turns a payload request into a byte-serial command stream for the SPI master driving the 802.15.4 radio. It flushes and loads the TX FIFO with an addressed frame, then issues the transmit strobe only on clear channel, using binary-exponential backoff and a bounded retry count. It tracks SFD to detect end of transmission and reports done or fail. It sits between the game/link layer and the SPI command master.

## Interface
- PAYLOAD_BYTES, 4, payload length in bytes (1..120)
- MAX_RETRIES, 3, CCA-busy retries before failing (0..7)
- BACKOFF_CYCLES, 2048, base backoff length in clocks (power of two)
- SFD_TIMEOUT, 65535, maximum clocks spent in each SFD wait phase
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- DIn  in  8*PAYLOAD_BYTES  payload, sampled at request acceptance
- SrcAddr, DstAddr  in  8 each  sampled with DIn
- InRequest  in  1  level request to send
- InValid  out  1  one-cycle pulse: DIn/addresses captured
- CCA  in  1  clear-channel indication from radio
- SFD  in  1  start-of-frame-delimiter pin from radio
- Command  out  8  command/data byte to SPI master
- CmdValid  out  1  Command holds valid data
- CmdReady  in  1  SPI master accepts Command this edge
- TransmitDone  out  1  one-cycle pulse, frame sent
- TransmitFail  out  1  one-cycle pulse, retries exhausted or SFD timeout
- CurState  out  4  current state encoding (debug)

## Operation
- States, encoded 0..13: IDLE, FLUSH, FIFO_ADDR, LEN, DST, SRC, PAYLOAD, CCA_CHECK, BACKOFF, STROBE, WAIT_SFD_HI, WAIT_SFD_LO, DONE, FAIL.
- IDLE: when InRequest=1, capture DIn, SrcAddr, and DstAddr, pulse InValid, clear the retry count, and go to FLUSH.
- Byte states present their Command with CmdValid=1 and advance only on an edge where CmdReady=1.
  - FLUSH sends 8'h09 (SFLUSHTX).
  - FIFO_ADDR sends 8'h3E (TXFIFO).
  - LEN sends PAYLOAD_BYTES+4 (two address bytes plus two radio-appended FCS bytes).
  - DST sends DstAddr.
  - SRC sends SrcAddr.
  - PAYLOAD sends captured bytes MSB first; an internal index runs 0..PAYLOAD_BYTES-1.
- CCA_CHECK (CmdValid=0, one cycle):
  - CCA=1 goes to STROBE.
  - CCA=0 with retries<MAX_RETRIES increments retries and goes to BACKOFF.
  - Otherwise goes to FAIL.
- BACKOFF waits BACKOFF_CYCLES<<retries clocks (retries already incremented), then returns to CCA_CHECK. The FIFO is not reloaded.
- STROBE sends 8'h04 (STXON), then goes to WAIT_SFD_HI.
- WAIT_SFD_HI waits for SFD=1; WAIT_SFD_LO then waits for SFD=0. Each phase restarts the timer. SFD_TIMEOUT clocks without the awaited level goes to FAIL.
- DONE pulses TransmitDone; FAIL pulses TransmitFail. Both return to IDLE next cycle.
- InRequest is ignored outside IDLE. A still-asserted InRequest on return to IDLE starts a new frame; no idle cycle is required beyond the DONE/FAIL cycle.

## Timing
- Reset values: Command=8'h00, CmdValid=0, InValid=0, TransmitDone=0, TransmitFail=0, CurState=IDLE (0). Retry count, timer, and byte index are zeroed.
- Reset asserted mid-frame drops CmdValid immediately (asynchronously) and discards the frame. No done/fail pulse is produced.
- Request to first command: InValid is high in the cycle after the InRequest-sampling edge, and FLUSH/CmdValid are valid in that same cycle.
- With CmdReady tied high, the command stream is PAYLOAD_BYTES+6 consecutive cycles, with one extra CCA_CHECK cycle before STROBE.
- Command and CmdValid are registered. Command must not change while CmdValid=1 and CmdReady=0.
- Timer width is clog2(max(BACKOFF_CYCLES<<MAX_RETRIES, SFD_TIMEOUT))+1. It counts down and expires at zero with no wrap.
- SFD is sampled directly and is assumed synchronous to Clock. SFD already high on entry to WAIT_SFD_HI is accepted in the first cycle.

## Structure
- Shared package radio_pkg holds:
  - opcode constants CMD_SFLUSHTX=8'h09, CMD_TXFIFO=8'h3E, CMD_STXON=8'h04;
  - the 4-bit state enumeration;
  - FCS_BYTES=2.
- One sub-module, tx_wait_timer: a loadable down-counter with load value, load strobe, and expired flag. It is shared by BACKOFF and both SFD wait phases.
- The payload is held in a shift register, shifted left 8 bits on each accepted PAYLOAD byte.

## Test plan
- Defaults, DIn=32'h12345678, SrcAddr=8'hAB, DstAddr=8'hCD, CmdReady=1, CCA=1; pulse SFD high 1 cycle, then low -> Command stream 09,3E,08,CD,AB,12,34,56,78,04, then one TransmitDone pulse, then IDLE.
- CmdReady toggling 1-of-3 cycles -> identical byte sequence, with Command stable whenever CmdValid=1 and CmdReady=0.
- CCA=0 for first two checks, then 1 -> BACKOFF lengths 4096 then 8192 clocks, then STXON, then done.
- CCA held 0, MAX_RETRIES=3 -> three backoffs (4096, 8192, 16384), then a TransmitFail pulse with no STXON.
- SFD never rises -> TransmitFail exactly SFD_TIMEOUT cycles after STXON is accepted.
- Reset asserted during PAYLOAD -> outputs 0 at once; after release, a new InRequest restarts from FLUSH.
